// File: rtl/mul_sub_sequencer_pkg.sv
// Shared constants and types for the SUB/MUL sequencer.
package mul_sub_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W_DEF = 4;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

endpackage

// File: rtl/mul_sub_sequencer_if.sv
// Request/result bundle between the operand registers and the sequencer.
interface mul_sub_sequencer_if
    import mul_sub_sequencer_pkg::*;
#(
    parameter int unsigned W = DATA_W
);
    logic           start;
    logic           op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] q;
    logic           borrow;

    modport master (
        output start, op, a, b,
        input  busy, done, q, borrow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, q, borrow
    );
endinterface

// File: rtl/add8_masked.sv
// Combinational 8-bit ripple adder with per-operand enable gates and a carry-in.
module add8_masked (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       a_m_i,
    input  logic       b_m_i,
    input  logic       c_we_i,
    output logic [7:0] q_o,
    output logic       c_wy_o
);
    logic [7:0] a_g;
    logic [7:0] b_g;

    assign a_g = a_m_i ? a_i : 8'h00;
    assign b_g = b_m_i ? b_i : 8'h00;

    // Bitwise ripple: sum and carry per stage.
    always_comb begin
        logic [8:0] carry;
        carry    = '0;
        q_o      = '0;
        carry[0] = c_we_i;
        for (int i = 0; i < 8; i++) begin
            q_o[i]     = a_g[i] ^ b_g[i] ^ carry[i];
            carry[i+1] = (a_g[i] & b_g[i]) | (carry[i] & (a_g[i] ^ b_g[i]));
        end
        c_wy_o = carry[8];
    end
endmodule

// File: rtl/mul_sub_sequencer.sv
// Multicycle controller reusing one masked adder for SUB (1 step) and MUL (W shift-add steps).
module mul_sub_sequencer
    import mul_sub_sequencer_pkg::*;
#(
    parameter int unsigned W     = DATA_W,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic                clk_i,
    input logic                rst_ni,
    mul_sub_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     acc_hi_q, acc_hi_d;
    logic [W-1:0]     mq_q, mq_d;
    logic [2*W-1:0]   q_q, q_d;
    logic             borrow_q, borrow_d;

    logic [W-1:0]     add_a, add_b, add_sum;
    logic             add_bm, add_cin, add_cout;

    // Adder operand routing: SUB adds ~B with carry-in; MUL conditionally adds the multiplicand.
    always_comb begin
        add_a   = a_q;
        add_b   = ~b_q;
        add_bm  = 1'b1;
        add_cin = 1'b1;
        if (op_q == OP_MUL) begin
            add_a   = acc_hi_q;
            add_b   = a_q;
            add_bm  = mq_q[0];
            add_cin = 1'b0;
        end
    end

    add8_masked u_add (
        .a_i    (add_a),
        .b_i    (add_b),
        .a_m_i  (1'b1),
        .b_m_i  (add_bm),
        .c_we_i (add_cin),
        .q_o    (add_sum),
        .c_wy_o (add_cout)
    );

    // Next-state: operand capture, one SUB step or W MUL shift-add steps, then a DONE cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        mq_d     = mq_q;
        q_d      = q_q;
        borrow_d = borrow_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    mq_d     = bus.b;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (op_q == OP_SUB) begin
                    q_d      = {{W{1'b0}}, add_sum};
                    borrow_d = ~add_cout;
                    state_d  = StFin;
                end else begin
                    {acc_hi_d, mq_d} = {add_cout, add_sum, mq_q[W-1:1]};
                    cnt_d            = cnt_q + CntOne;
                    if (cnt_q == CntLast) begin
                        q_d      = {add_cout, add_sum, mq_q[W-1:1]};
                        borrow_d = 1'b0;
                        state_d  = StFin;
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi_q <= '0;
            mq_q     <= '0;
            q_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            mq_q     <= mq_d;
            q_q      <= q_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.busy   = (state_q == StRun);
    assign bus.done   = (state_q == StFin);
    assign bus.q      = q_q;
    assign bus.borrow = borrow_q;
endmodule
